// File: rtl/adc_serial_tx_pkg.sv
// adc_serial_tx_pkg: shared mode/state encodings and checkerboard words for the serial ADC emulator
package adc_serial_tx_pkg;
    typedef enum logic [1:0] {MODE_STREAM, MODE_RAMP, MODE_CHECKER, MODE_CONST} mode_t;
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [13:0] CHECKER_A = 14'h2AAA;
    localparam logic [13:0] CHECKER_B = 14'h1555;
endpackage

// File: rtl/adc_tx_pattern.sv
// adc_tx_pattern: ramp counter, checker phase and mode mux choosing the next word to serialize
module adc_tx_pattern
    import adc_serial_tx_pkg::*;
#(
    parameter int DATA_BITS = 14,
    parameter logic [DATA_BITS-1:0] IDLE_WORD = '0
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 advance,
    input  logic                 restart,
    input  logic [1:0]           mode,
    input  logic [DATA_BITS-1:0] pattern_value,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic [DATA_BITS-1:0] word,
    output logic                 underrun
);
    mode_t m;
    logic [DATA_BITS-1:0] ramp, ramp_cur;
    logic phase, phase_cur;
    // a burst restart overrides the stored generators so the first word is always 0 / CHECKER_A
    always_comb begin
        m = mode_t'(mode);
        ramp_cur = restart ? '0 : ramp;
        phase_cur = restart ? 1'b0 : phase;
        underrun = (m == MODE_STREAM) && !in_valid;
        word = (m == MODE_STREAM) ? (in_valid ? in_data : IDLE_WORD) :
               (m == MODE_RAMP) ? ramp_cur :
               (m == MODE_CHECKER) ? (phase_cur ? DATA_BITS'(CHECKER_B) : DATA_BITS'(CHECKER_A)) :
               pattern_value;
    end
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            ramp <= '0;
            phase <= 1'b0;
        end else if (advance) begin
            ramp <= ramp_cur + DATA_BITS'(m == MODE_RAMP);
            phase <= phase_cur ^ (m == MODE_CHECKER);
        end
    end
endmodule

// File: rtl/adc_serial_tx.sv
// adc_serial_tx: serializes DATA_BITS-wide words MSB-first with a half-frame marker,
// sourcing words from a stream input or built-in test patterns
module adc_serial_tx
    import adc_serial_tx_pkg::*;
#(
    parameter int DATA_BITS = 14,
    parameter logic [DATA_BITS-1:0] IDLE_WORD = '0
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [DATA_BITS-1:0] pattern_value,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 ser_out,
    output logic                 frame_out,
    input  logic                 cnt_clear,
    output logic [31:0]          frame_cnt,
    output logic [15:0]          underrun_cnt
);
    localparam int CW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] HALF = CW'(DATA_BITS / 2);
    state_t state;
    logic [CW-1:0] bit_cnt;
    logic [DATA_BITS-1:0] shreg, word;
    logic underrun, frame_end, restart, load;
    always_comb begin
        frame_end = (state == RUN) && (bit_cnt == LAST);
        restart = (state == IDLE) && enable;
        load = restart || (frame_end && enable);
        in_ready = (mode_t'(mode) == MODE_STREAM) && load;
    end
    adc_tx_pattern #(.DATA_BITS(DATA_BITS), .IDLE_WORD(IDLE_WORD)) u_pattern (
        .clk(clk),
        .rst_b(rst_b),
        .advance(load),
        .restart(restart),
        .mode(mode),
        .pattern_value(pattern_value),
        .in_data(in_data),
        .in_valid(in_valid),
        .word(word),
        .underrun(underrun)
    );
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state <= IDLE;
            bit_cnt <= '0;
            shreg <= '0;
            ser_out <= 1'b0;
            frame_out <= 1'b0;
            frame_cnt <= '0;
            underrun_cnt <= '0;
        end else begin
            if (load) begin
                state <= RUN;
                bit_cnt <= '0;
                shreg <= word << 1;
                ser_out <= word[DATA_BITS-1];
                frame_out <= 1'b1;
            end else if (frame_end || state == IDLE) begin
                state <= IDLE;
                bit_cnt <= '0;
                ser_out <= 1'b0;
                frame_out <= 1'b0;
            end else begin
                bit_cnt <= bit_cnt + CW'(1);
                shreg <= shreg << 1;
                ser_out <= shreg[DATA_BITS-1];
                frame_out <= (bit_cnt + CW'(1)) < HALF;
            end
            frame_cnt <= cnt_clear ? '0 : frame_cnt + 32'(frame_end);
            underrun_cnt <= cnt_clear ? '0 : underrun_cnt + 16'(load && underrun && underrun_cnt != 16'hFFFF);
        end
    end
endmodule

// File: tb/tb_adc_serial_tx.sv
// tb_adc_serial_tx: frame-level queue model plus table, directed and random checks of adc_serial_tx
module tb_adc_serial_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_b, enable, in_valid, in_ready, ser_out, frame_out, cnt_clear;
    logic [1:0] mode;
    logic [13:0] pattern_value, in_data;
    logic [31:0] frame_cnt;
    logic [15:0] underrun_cnt;

    adc_serial_tx dut (
        .clk(clk), .rst_b(rst_b), .enable(enable), .mode(mode),
        .pattern_value(pattern_value), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .ser_out(ser_out), .frame_out(frame_out),
        .cnt_clear(cnt_clear), .frame_cnt(frame_cnt), .underrun_cnt(underrun_cnt)
    );

    // narrow instance so the ramp wrap is reachable in a few cycles
    logic s_en, s_ready, s_ser, s_frm;
    logic [31:0] s_fcnt;
    logic [15:0] s_ucnt;
    adc_serial_tx #(.DATA_BITS(4)) dut4 (
        .clk(clk), .rst_b(rst_b), .enable(s_en), .mode(2'd1),
        .pattern_value(4'h0), .in_data(4'h0), .in_valid(1'b0),
        .in_ready(s_ready), .ser_out(s_ser), .frame_out(s_frm),
        .cnt_clear(1'b0), .frame_cnt(s_fcnt), .underrun_cnt(s_ucnt)
    );

    int vectors = 0;
    int miscompares = 0;

    bit m_run = 0;
    logic [1:0] m_q[$];
    logic m_ser = 0, m_frm = 0, m_phase = 0;
    logic [31:0] m_fcnt = 0;
    logic [15:0] m_ucnt = 0;
    logic [13:0] m_ramp = 0;
    logic [13:0] got;

    typedef struct packed {
        logic [1:0]  mode;
        logic [13:0] pattern;
        logic [13:0] data;
        logic        valid;
        logic [13:0] word;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_ready();
        return (mode == 2'd0) && enable && (!m_run || m_q.size() == 0);
    endfunction

    // each load queues the whole frame's (data, marker) pairs; each edge pops one
    task automatic model_edge();
        logic [13:0] w;
        bit fin;
        if (!rst_b) begin
            m_run = 0; m_q.delete(); m_ser = 0; m_frm = 0;
            m_fcnt = 0; m_ucnt = 0; m_ramp = 0; m_phase = 0;
            return;
        end
        fin = m_run && m_q.size() == 0;
        if (fin) m_fcnt++;
        if (!m_run || fin) begin
            if (enable) begin
                if (!m_run) begin m_ramp = 0; m_phase = 0; end
                case (mode)
                    2'd0: begin
                        if (in_valid) w = in_data;
                        else begin
                            w = 14'h0000;
                            if (m_ucnt != 16'hFFFF) m_ucnt++;
                        end
                    end
                    2'd1: begin w = m_ramp; m_ramp++; end
                    2'd2: begin w = m_phase ? 14'h1555 : 14'h2AAA; m_phase = ~m_phase; end
                    default: w = pattern_value;
                endcase
                for (int i = 0; i < 14; i++) m_q.push_back({w[13-i], 1'(i < 7)});
                {m_ser, m_frm} = m_q.pop_front();
                m_run = 1;
            end else begin
                m_run = 0; m_ser = 0; m_frm = 0;
            end
        end else begin
            {m_ser, m_frm} = m_q.pop_front();
        end
        if (cnt_clear) begin m_fcnt = 0; m_ucnt = 0; end
    endtask

    task automatic step();
        #1;
        chk("in_ready", 32'(in_ready), 32'(exp_ready()));
        model_edge();
        @(posedge clk);
        @(negedge clk);
        chk("ser_out", 32'(ser_out), 32'(m_ser));
        chk("frame_out", 32'(frame_out), 32'(m_frm));
        chk("frame_cnt", frame_cnt, m_fcnt);
        chk("underrun_cnt", 32'(underrun_cnt), 32'(m_ucnt));
        got = {got[12:0], ser_out};
    endtask

    task automatic frame(input string name, input logic [13:0] exp);
        for (int b = 0; b < 14; b++) step();
        chk(name, 32'(got), 32'(exp));
    endtask

    initial begin
        logic [3:0] w4, f4;
        tbl[0]  = '{2'd3, 14'h3001, 14'h0000, 1'b0, 14'h3001};
        tbl[1]  = '{2'd3, 14'h3001, 14'h0000, 1'b0, 14'h3001};
        tbl[2]  = '{2'd0, 14'h0000, 14'h1234, 1'b1, 14'h1234};
        tbl[3]  = '{2'd0, 14'h0000, 14'h0ABC, 1'b1, 14'h0ABC};
        tbl[4]  = '{2'd0, 14'h0000, 14'h1111, 1'b0, 14'h0000};
        tbl[5]  = '{2'd0, 14'h0000, 14'h1111, 1'b1, 14'h1111};
        tbl[6]  = '{2'd1, 14'h0000, 14'h0000, 1'b0, 14'h0000};
        tbl[7]  = '{2'd1, 14'h0000, 14'h0000, 1'b0, 14'h0001};
        tbl[8]  = '{2'd2, 14'h0000, 14'h0000, 1'b0, 14'h2AAA};
        tbl[9]  = '{2'd2, 14'h0000, 14'h0000, 1'b0, 14'h1555};
        tbl[10] = '{2'd1, 14'h0000, 14'h0000, 1'b0, 14'h0002};
        tbl[11] = '{2'd2, 14'h0000, 14'h0000, 1'b0, 14'h2AAA};

        rst_b = 0; enable = 0; mode = 0; pattern_value = 0; in_data = 0;
        in_valid = 0; cnt_clear = 0; s_en = 0; got = 0;
        @(negedge clk);
        step(); step();
        rst_b = 1;
        step();
        chk("reset_ser", 32'(ser_out), 32'h0);
        chk("reset_fcnt", frame_cnt, 32'h0);

        for (int i = 0; i < 12; i++) begin
            mode = tbl[i].mode; pattern_value = tbl[i].pattern;
            in_data = tbl[i].data; in_valid = tbl[i].valid; enable = 1;
            frame($sformatf("tbl_word%0d", i), tbl[i].word);
        end
        chk("underrun_once", 32'(underrun_cnt), 32'h1);
        cnt_clear = 1; enable = 0;
        step();
        cnt_clear = 0;
        chk("clear_at_frame_end", frame_cnt, 32'h0);

        mode = 3; pattern_value = 14'h3001; enable = 1;
        for (int b = 0; b < 4; b++) step();
        enable = 0;
        for (int b = 0; b < 10; b++) step();
        chk("drop_word", 32'(got), 32'h3001);
        step(); step();
        chk("idle_ser", 32'(ser_out), 32'h0);
        chk("idle_frame", 32'(frame_out), 32'h0);
        mode = 2; enable = 1;
        frame("reenable_checker", 14'h2AAA);
        for (int b = 0; b < 8; b++) step();
        rst_b = 0;
        step();
        rst_b = 1;
        chk("rst_ser", 32'(ser_out), 32'h0);
        chk("rst_frame", 32'(frame_out), 32'h0);
        chk("rst_fcnt", frame_cnt, 32'h0);
        chk("rst_ucnt", 32'(underrun_cnt), 32'h0);

        for (int n = 0; n < 400; n++) begin
            enable = $urandom_range(0, 7) != 0;
            mode = 2'($urandom_range(0, 3));
            in_data = 14'($urandom);
            in_valid = $urandom_range(0, 3) != 0;
            pattern_value = 14'($urandom);
            cnt_clear = $urandom_range(0, 49) == 0;
            rst_b = $urandom_range(0, 199) != 0;
            step();
        end
        rst_b = 1; enable = 0; cnt_clear = 0;
        for (int b = 0; b < 16; b++) step();

        s_en = 1;
        w4 = 0; f4 = 0;
        for (int n = 0; n < 20; n++) begin
            for (int b = 0; b < 4; b++) begin
                @(posedge clk);
                @(negedge clk);
                w4 = {w4[2:0], s_ser};
                f4 = {f4[2:0], s_frm};
            end
            chk("ramp4_word", 32'(w4), 32'(n % 16));
            chk("ramp4_frame", 32'(f4), 32'hC);
        end
        chk("ramp4_fcnt", s_fcnt, 32'd19);
        s_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
